// File: rtl/power_fx.sv
// Fixed-point signed power unit: a**b by MSB-first square-and-multiply on magnitudes,
// with a restoring reciprocal divide for negative exponents. Result is Q(M-F-1).F signed.
module power_fx #(
    parameter int unsigned N     = 16,
    parameter int unsigned M     = 24,
    parameter int unsigned F     = 8,
    parameter logic [2:0]  EXECB = 3'd4,
    parameter logic [3:0]  POW   = 4'd9
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [2:0]   state,
    input  logic [3:0]   opcode,
    output logic [M-1:0] o_power,
    output logic         error,
    output logic         done
);

    localparam int unsigned CW  = $clog2(N + F + 2);
    localparam logic [M-1:0] LIM = M'(1) << (M - F - 1);

    typedef enum logic [2:0] {IDLE, EXP, DIV, FIN, HOLD} fsm_e;

    fsm_e            fsm_q, fsm_d;
    logic [M-1:0]    acc_q, acc_d;
    logic [M-1:0]    amag_q, amag_d;
    logic [N-1:0]    bsh_q, bsh_d;
    logic            bneg_q, bneg_d;
    logic            rneg_q, rneg_d;
    logic [M-1:0]    q_q, q_d;
    logic [M-1:0]    rem_q, rem_d;
    logic            ovf_q, ovf_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [M-1:0]    pw_d;
    logic            err_d, done_d;

    logic            go;
    logic [N-1:0]    a_abs, b_abs;
    logic [2*M-1:0]  sq, pr;
    logic [M-1:0]    nxt, mag;
    logic [M:0]      rem_sh;
    logic            ovf_n, fin_err;

    assign go    = (state == EXECB) && (opcode == POW);
    assign a_abs = a[N-1] ? (~a + N'(1)) : a;
    assign b_abs = b[N-1] ? (~b + N'(1)) : b;

    // Next-state, datapath and registered-output logic
    always_comb begin
        fsm_d   = fsm_q;
        acc_d   = acc_q;
        amag_d  = amag_q;
        bsh_d   = bsh_q;
        bneg_d  = bneg_q;
        rneg_d  = rneg_q;
        q_d     = q_q;
        rem_d   = rem_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        pw_d    = o_power;
        err_d   = error;
        done_d  = done;
        sq      = '0;
        pr      = '0;
        nxt     = '0;
        mag     = '0;
        rem_sh  = '0;
        ovf_n   = 1'b0;
        fin_err = 1'b0;

        case (fsm_q)
            IDLE: begin
                if (go) begin
                    acc_d  = M'(1);
                    amag_d = M'(a_abs);
                    bsh_d  = b_abs;
                    bneg_d = b[N-1];
                    rneg_d = a[N-1] & b_abs[0];
                    q_d    = '0;
                    rem_d  = '0;
                    ovf_d  = 1'b0;
                    cnt_d  = CW'(N - 1);
                    done_d = 1'b0;
                    err_d  = 1'b0;
                    // 0 to a negative power: q stays 0, which FIN reports as an error
                    fsm_d  = (a == '0 && b[N-1]) ? FIN : EXP;
                end
            end
            EXP: begin
                if (!go) begin
                    fsm_d = IDLE;
                end else begin
                    sq    = (2*M)'(acc_q) * (2*M)'(acc_q);
                    ovf_n = ovf_q | (|sq[2*M-1:M]);
                    nxt   = sq[M-1:0];
                    if (bsh_q[N-1]) begin
                        pr    = (2*M)'(nxt) * (2*M)'(amag_q);
                        ovf_n = ovf_n | (|pr[2*M-1:M]);
                        nxt   = pr[M-1:0];
                    end
                    acc_d = nxt;
                    ovf_d = ovf_n;
                    bsh_d = bsh_q << 1;
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == '0) begin
                        if (bneg_q) begin
                            fsm_d = DIV;
                            cnt_d = CW'(F);
                        end else begin
                            fsm_d = FIN;
                        end
                    end
                end
            end
            DIV: begin
                // Restoring divide of 2^F (one dividend bit per cycle) by acc
                if (!go) begin
                    fsm_d = IDLE;
                end else begin
                    rem_sh = {rem_q, (cnt_q == CW'(F))};
                    if (rem_sh >= {1'b0, acc_q}) begin
                        rem_d = M'(rem_sh - {1'b0, acc_q});
                        q_d   = {q_q[M-2:0], 1'b1};
                    end else begin
                        rem_d = rem_sh[M-1:0];
                        q_d   = {q_q[M-2:0], 1'b0};
                    end
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == '0) begin
                        fsm_d = FIN;
                    end
                end
            end
            FIN: begin
                if (bneg_q) begin
                    mag     = q_q;
                    fin_err = ovf_q | (q_q == '0);
                end else begin
                    mag     = acc_q << F;
                    fin_err = ovf_q | (acc_q > LIM) | ((acc_q == LIM) & ~rneg_q);
                end
                pw_d   = fin_err ? '0 : (rneg_q ? (~mag + M'(1)) : mag);
                err_d  = fin_err;
                done_d = 1'b1;
                fsm_d  = HOLD;
            end
            HOLD: begin
                if (!go) begin
                    done_d = 1'b0;
                    fsm_d  = IDLE;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            fsm_q   <= IDLE;
            acc_q   <= '0;
            amag_q  <= '0;
            bsh_q   <= '0;
            bneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            q_q     <= '0;
            rem_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
            o_power <= '0;
            error   <= 1'b0;
            done    <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            acc_q   <= acc_d;
            amag_q  <= amag_d;
            bsh_q   <= bsh_d;
            bneg_q  <= bneg_d;
            rneg_q  <= rneg_d;
            q_q     <= q_d;
            rem_q   <= rem_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
            o_power <= pw_d;
            error   <= err_d;
            done    <= done_d;
        end
    end

endmodule
